// File: rtl/vga_pkg.sv
// Shared types and default 640x480@60 timing for the VGA raster generator.
package vga_pkg;

  typedef enum logic [1:0] {ACT, FP, SYNC, BP} seg_state_t;

  localparam int POS_W     = 10;
  localparam int MAX_TOTAL = 1024;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  function automatic int seg_total(input int act, input int fp, input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter plus ACT/FP/SYNC/BP segment FSM.
// Next-state and wrap are exported so the top can register coherent outputs.
module vga_axis_counter import vga_pkg::*; #(
  parameter int SEG_ACT  = DEF_H_ACTIVE,
  parameter int SEG_FP   = DEF_H_FP,
  parameter int SEG_SYNC = DEF_H_SYNC,
  parameter int SEG_BP   = DEF_H_BP
) (
  input  logic             clk,
  input  logic             i_clear,
  input  logic             i_advance,
  output logic [POS_W-1:0] o_pos,
  output logic [1:0]       o_state_next,
  output logic             o_wrap
);

  localparam int TOTAL = seg_total(SEG_ACT, SEG_FP, SEG_SYNC, SEG_BP);

  if (TOTAL > MAX_TOTAL || SEG_ACT == 0 || SEG_FP == 0 || SEG_SYNC == 0 || SEG_BP == 0) begin : g_bad_params
    $error("vga_axis_counter: segment lengths must be nonzero with a total of at most 1024");
  end

  localparam logic [POS_W-1:0] END_ACT  = POS_W'(SEG_ACT - 1);
  localparam logic [POS_W-1:0] END_FP   = POS_W'(SEG_ACT + SEG_FP - 1);
  localparam logic [POS_W-1:0] END_SYNC = POS_W'(SEG_ACT + SEG_FP + SEG_SYNC - 1);
  localparam logic [POS_W-1:0] END_BP   = POS_W'(TOTAL - 1);

  logic [POS_W-1:0] r_pos;
  seg_state_t       r_state;
  logic [POS_W-1:0] w_pos_next;
  seg_state_t       w_state_next;
  logic             w_at_end;
  logic             w_wrap;

  always_ff @(posedge clk) begin
    r_pos   <= w_pos_next;
    r_state <= w_state_next;
  end

  // Clear has priority over advance, so the clearing edge never reports a wrap.
  always_comb begin
    w_pos_next   = r_pos;
    w_state_next = r_state;
    w_at_end     = (r_pos == END_BP);
    w_wrap       = 1'b0;
    if (i_clear) begin
      w_pos_next   = '0;
      w_state_next = ACT;
    end else if (i_advance) begin
      w_wrap     = w_at_end;
      w_pos_next = w_at_end ? '0 : r_pos + POS_W'(1);
      case (r_state)
        ACT:     if (r_pos == END_ACT)  w_state_next = FP;
        FP:      if (r_pos == END_FP)   w_state_next = SYNC;
        SYNC:    if (r_pos == END_SYNC) w_state_next = BP;
        BP:      if (r_pos == END_BP)   w_state_next = ACT;
        default: w_state_next = ACT;
      endcase
    end
  end

  assign o_pos        = r_pos;
  assign o_state_next = w_state_next;
  assign o_wrap       = w_wrap;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA pixel-timing generator: raster position, blank, syncs and frame/line pulses,
// all registered on pix_clk and held in reset until the clock wizard locks.
module vga_timing_gen import vga_pkg::*; #(
  parameter int   H_ACTIVE    = DEF_H_ACTIVE,
  parameter int   H_FP        = DEF_H_FP,
  parameter int   H_SYNC      = DEF_H_SYNC,
  parameter int   H_BP        = DEF_H_BP,
  parameter int   V_ACTIVE    = DEF_V_ACTIVE,
  parameter int   V_FP        = DEF_V_FP,
  parameter int   V_SYNC      = DEF_V_SYNC,
  parameter int   V_BP        = DEF_V_BP,
  parameter logic SYNC_ACTIVE = 1'b0
) (
  input  logic       pix_clk,
  input  logic       rst_n,
  input  logic       locked,
  output logic [9:0] pos_h,
  output logic [9:0] pos_v,
  output logic       blank,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_start,
  output logic       line_start
);

  logic       w_clear;
  logic       w_run;
  logic       w_h_wrap;
  logic       w_v_wrap;
  logic [1:0] w_h_state_next;
  logic [1:0] w_v_state_next;

  logic r_blank;
  logic r_hsync;
  logic r_vsync;
  logic r_frame_start;
  logic r_line_start;

  assign w_clear = !rst_n || !locked;
  assign w_run   = !w_clear;

  vga_axis_counter #(
    .SEG_ACT  (H_ACTIVE),
    .SEG_FP   (H_FP),
    .SEG_SYNC (H_SYNC),
    .SEG_BP   (H_BP)
  ) u_h_axis (
    .clk          (pix_clk),
    .i_clear      (w_clear),
    .i_advance    (w_run),
    .o_pos        (pos_h),
    .o_state_next (w_h_state_next),
    .o_wrap       (w_h_wrap)
  );

  vga_axis_counter #(
    .SEG_ACT  (V_ACTIVE),
    .SEG_FP   (V_FP),
    .SEG_SYNC (V_SYNC),
    .SEG_BP   (V_BP)
  ) u_v_axis (
    .clk          (pix_clk),
    .i_clear      (w_clear),
    .i_advance    (w_h_wrap),
    .o_pos        (pos_v),
    .o_state_next (w_v_state_next),
    .o_wrap       (w_v_wrap)
  );

  // Outputs are computed from the counters' next state so they land with the position they describe.
  always_ff @(posedge pix_clk) begin
    if (!rst_n || !locked) begin
      r_blank       <= 1'b0;
      r_hsync       <= ~SYNC_ACTIVE;
      r_vsync       <= ~SYNC_ACTIVE;
      r_frame_start <= 1'b0;
      r_line_start  <= 1'b0;
    end else begin
      r_blank       <= (w_h_state_next != ACT) || (w_v_state_next != ACT);
      r_hsync       <= (w_h_state_next == SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      r_vsync       <= (w_v_state_next == SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      r_line_start  <= w_h_wrap;
      r_frame_start <= w_v_wrap;
    end
  end

  assign blank       = r_blank;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign frame_start = r_frame_start;
  assign line_start  = r_line_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: default 800x525 build plus a 7x6 build, both
// driven by the same reset/lock and checked every cycle against a position-range model.
module tb_vga_timing_gen;

  typedef struct packed {
    logic [9:0] h;
    logic [9:0] v;
    logic       blank;
    logic       hs;
    logic       vs;
    logic       fs;
    logic       ls;
  } obs_t;

  logic       pix_clk;
  logic       rst_n;
  logic       locked;
  logic [9:0] pos_h, pos_v, s_pos_h, s_pos_v;
  logic       blank, hsync, vsync, frame_start, line_start;
  logic       s_blank, s_hsync, s_vsync, s_frame_start, s_line_start;

  obs_t got_d, got_s, ed, es;
  obs_t q_def[$];
  obs_t q_sml[$];
  int   total = 0;
  int   bad   = 0;
  int   mh = 0, mv = 0, sh = 0, sv = 0;

  assign got_d = {pos_h, pos_v, blank, hsync, vsync, frame_start, line_start};
  assign got_s = {s_pos_h, s_pos_v, s_blank, s_hsync, s_vsync, s_frame_start, s_line_start};

  vga_timing_gen dut (
    .pix_clk(pix_clk), .rst_n(rst_n), .locked(locked),
    .pos_h(pos_h), .pos_v(pos_v), .blank(blank), .hsync(hsync), .vsync(vsync),
    .frame_start(frame_start), .line_start(line_start)
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_ACTIVE(1'b0)
  ) dut_small (
    .pix_clk(pix_clk), .rst_n(rst_n), .locked(locked),
    .pos_h(s_pos_h), .pos_v(s_pos_v), .blank(s_blank), .hsync(s_hsync), .vsync(s_vsync),
    .frame_start(s_frame_start), .line_start(s_line_start)
  );

  initial pix_clk = 1'b0;
  always #5 pix_clk = ~pix_clk;

  function automatic obs_t model_obs(input int h, input int v,
                                     input int ha, input int hfp, input int hsw, input int hbp,
                                     input int va, input int vfp, input int vsw, input int vbp);
    obs_t o;
    o.h     = 10'(h);
    o.v     = 10'(v);
    o.blank = (h >= ha) || (v >= va);
    o.hs    = !((h >= ha + hfp) && (h < ha + hfp + hsw));
    o.vs    = !((v >= va + vfp) && (v < va + vfp + vsw));
    o.fs    = (h == 0) && (v == 0);
    o.ls    = (h == 0);
    return o;
  endfunction

  function automatic obs_t reset_obs();
    obs_t o;
    o = '0;
    o.hs = 1'b1;
    o.vs = 1'b1;
    return o;
  endfunction

  task automatic adv(inout int h, inout int v, input int ht, input int vt);
    if (h == ht - 1) begin
      h = 0;
      v = (v == vt - 1) ? 0 : v + 1;
    end else begin
      h = h + 1;
    end
  endtask

  // Drive one edge worth of inputs and queue what both builds must show after it.
  task automatic cycle(input logic r, input logic l);
    rst_n  = r;
    locked = l;
    if (!r || !l) begin
      mh = 0; mv = 0; sh = 0; sv = 0;
      q_def.push_back(reset_obs());
      q_sml.push_back(reset_obs());
    end else begin
      adv(mh, mv, 800, 525);
      adv(sh, sv, 7, 6);
      q_def.push_back(model_obs(mh, mv, 640, 16, 96, 48, 480, 10, 2, 33));
      q_sml.push_back(model_obs(sh, sv, 4, 1, 1, 1, 3, 1, 1, 1));
    end
    @(posedge pix_clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b1);
      ed = q_def.pop_front(); es = q_sml.pop_front();
      total++; if (got_d !== ed) begin bad++; $display("FAIL reset_def cyc=%0d got=%h exp=%h", i, got_d, ed); end
      total++; if (got_s !== es) begin bad++; $display("FAIL reset_small cyc=%0d got=%h exp=%h", i, got_s, es); end
    end
  endtask

  task automatic test_line();
    int blank_rise = -1;
    int hs_first = -1;
    int hs_cnt = 0, ls_cnt = 0, fs_cnt = 0;
    for (int i = 0; i < 1600; i++) begin
      cycle(1'b1, 1'b1);
      ed = q_def.pop_front(); es = q_sml.pop_front();
      total++; if (got_d !== ed) begin bad++; $display("FAIL line_def cyc=%0d got=%h exp=%h", i, got_d, ed); end
      total++; if (got_s !== es) begin bad++; $display("FAIL line_small cyc=%0d got=%h exp=%h", i, got_s, es); end
      if (i == 0) begin
        total++; if (pos_h !== 10'd1) begin bad++; $display("FAIL first_advance pos_h=%0d exp=1", pos_h); end
      end
      if (pos_v == 10'd0) begin
        if (blank === 1'b1 && blank_rise < 0) blank_rise = int'(pos_h);
        if (hsync === 1'b0) begin
          hs_cnt++;
          if (hs_first < 0) hs_first = int'(pos_h);
        end
      end
      if (line_start === 1'b1) ls_cnt++;
      if (frame_start === 1'b1) fs_cnt++;
    end
    total++; if (blank_rise != 640) begin bad++; $display("FAIL blank_rise got=%0d exp=640", blank_rise); end
    total++; if (hs_first != 656) begin bad++; $display("FAIL hsync_first got=%0d exp=656", hs_first); end
    total++; if (hs_cnt != 96) begin bad++; $display("FAIL hsync_width got=%0d exp=96", hs_cnt); end
    total++; if (ls_cnt != 2) begin bad++; $display("FAIL line_start_count got=%0d exp=2", ls_cnt); end
    total++; if (fs_cnt != 0) begin bad++; $display("FAIL early_frame_start got=%0d exp=0", fs_cnt); end
  endtask

  task automatic test_lock_loss();
    int n = 0;
    int fs_cnt = 0;
    while (!(mh == 300 && mv == 2) && n < 3000) begin
      cycle(1'b1, 1'b1);
      ed = q_def.pop_front(); es = q_sml.pop_front();
      total++; if (got_d !== ed) begin bad++; $display("FAIL lock_run_def got=%h exp=%h", got_d, ed); end
      total++; if (got_s !== es) begin bad++; $display("FAIL lock_run_small got=%h exp=%h", got_s, es); end
      n++;
    end
    total++; if (pos_h !== 10'd300 || pos_v !== 10'd2) begin bad++; $display("FAIL lock_reach got=(%0d,%0d) exp=(300,2)", pos_h, pos_v); end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0);
      ed = q_def.pop_front(); es = q_sml.pop_front();
      total++; if (got_d !== ed) begin bad++; $display("FAIL lock_low_def cyc=%0d got=%h exp=%h", i, got_d, ed); end
      total++; if (got_s !== es) begin bad++; $display("FAIL lock_low_small cyc=%0d got=%h exp=%h", i, got_s, es); end
    end
    for (int i = 0; i < 400; i++) begin
      cycle(1'b1, 1'b1);
      ed = q_def.pop_front(); es = q_sml.pop_front();
      total++; if (got_d !== ed) begin bad++; $display("FAIL relock_def cyc=%0d got=%h exp=%h", i, got_d, ed); end
      total++; if (got_s !== es) begin bad++; $display("FAIL relock_small cyc=%0d got=%h exp=%h", i, got_s, es); end
      if (i < 3) begin
        total++; if (pos_h !== 10'(i + 1)) begin bad++; $display("FAIL relock_count got=%0d exp=%0d", pos_h, i + 1); end
      end
      if (frame_start === 1'b1) fs_cnt++;
    end
    total++; if (fs_cnt != 0) begin bad++; $display("FAIL relock_frame_start got=%0d exp=0", fs_cnt); end
  endtask

  task automatic test_midframe_reset();
    int n = 0;
    while (!(mh == 799 && mv == 1) && n < 3000) begin
      cycle(1'b1, 1'b1);
      ed = q_def.pop_front(); es = q_sml.pop_front();
      total++; if (got_d !== ed) begin bad++; $display("FAIL mid_run_def got=%h exp=%h", got_d, ed); end
      total++; if (got_s !== es) begin bad++; $display("FAIL mid_run_small got=%h exp=%h", got_s, es); end
      n++;
    end
    total++; if (pos_h !== 10'd799 || pos_v !== 10'd1) begin bad++; $display("FAIL mid_reach_def got=(%0d,%0d) exp=(799,1)", pos_h, pos_v); end
    cycle(1'b0, 1'b1);
    ed = q_def.pop_front(); es = q_sml.pop_front();
    total++; if (got_d !== ed) begin bad++; $display("FAIL mid_reset_def got=%h exp=%h", got_d, ed); end
    total++; if (pos_v !== 10'd0 || blank !== 1'b0) begin bad++; $display("FAIL mid_no_vadv pos_v=%0d blank=%0b exp=0,0", pos_v, blank); end
    n = 0;
    while (!(sh == 6 && sv == 2) && n < 100) begin
      cycle(1'b1, 1'b1);
      ed = q_def.pop_front(); es = q_sml.pop_front();
      total++; if (got_d !== ed) begin bad++; $display("FAIL mid_run2_def got=%h exp=%h", got_d, ed); end
      total++; if (got_s !== es) begin bad++; $display("FAIL mid_run2_small got=%h exp=%h", got_s, es); end
      n++;
    end
    total++; if (s_pos_h !== 10'd6 || s_pos_v !== 10'd2) begin bad++; $display("FAIL mid_reach_small got=(%0d,%0d) exp=(6,2)", s_pos_h, s_pos_v); end
    cycle(1'b0, 1'b1);
    ed = q_def.pop_front(); es = q_sml.pop_front();
    total++; if (got_s !== es) begin bad++; $display("FAIL mid_reset_small got=%h exp=%h", got_s, es); end
    total++; if (s_pos_v !== 10'd0 || s_pos_h !== 10'd0 || s_blank !== 1'b0) begin bad++; $display("FAIL mid_small_pos got=(%0d,%0d,%0b) exp=(0,0,0)", s_pos_h, s_pos_v, s_blank); end
  endtask

  task automatic test_small_frames();
    int fs_cnt = 0, vs_cnt = 0, bl_cnt = 0, hs_cnt = 0;
    cycle(1'b0, 1'b1);
    ed = q_def.pop_front(); es = q_sml.pop_front();
    total++; if (got_s !== es) begin bad++; $display("FAIL small_reset got=%h exp=%h", got_s, es); end
    for (int i = 0; i < 126; i++) begin
      cycle(1'b1, 1'b1);
      ed = q_def.pop_front(); es = q_sml.pop_front();
      total++; if (got_d !== ed) begin bad++; $display("FAIL frames_def cyc=%0d got=%h exp=%h", i, got_d, ed); end
      total++; if (got_s !== es) begin bad++; $display("FAIL frames_small cyc=%0d got=%h exp=%h", i, got_s, es); end
      if (s_frame_start === 1'b1) fs_cnt++;
      if (s_vsync === 1'b0) vs_cnt++;
      if (s_hsync === 1'b0) hs_cnt++;
      if (s_blank === 1'b1) bl_cnt++;
    end
    total++; if (fs_cnt != 3) begin bad++; $display("FAIL small_frame_start got=%0d exp=3", fs_cnt); end
    total++; if (vs_cnt != 21) begin bad++; $display("FAIL small_vsync got=%0d exp=21", vs_cnt); end
    total++; if (hs_cnt != 18) begin bad++; $display("FAIL small_hsync got=%0d exp=18", hs_cnt); end
    total++; if (bl_cnt != 90) begin bad++; $display("FAIL small_blank got=%0d exp=90", bl_cnt); end
  endtask

  initial begin
    rst_n  = 1'b0;
    locked = 1'b1;
    #2;
    test_reset();
    test_line();
    test_lock_loss();
    test_midframe_reset();
    test_small_frames();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
